bk_test_pulse_gen_nch: RTL
==========================

Name: bk_test_pulse_gen_nch

Overview:
- Multi-channel breakdown-test feedback pulse generator on the 25 MHz domain.
- Successor to the fixed single-channel 20 ms / 875-cycle test pulser.
- Period, pulse width, initial delay and per-channel stagger are set at run time; runs continuous or as a counted burst.
- Drives CH_NUM feedback pulse lines into the breakdown-detection inputs for bench and self-test use.

Parameters:
- CH_NUM, 4, number of pulse channels (1..16).
- CNT_W, 20, width of the period/width/delay/stagger fields and the phase counter.
- CNT_P, 16, width of the completed-period counter.

Ports:
- i_clk_25m  input  1  25 MHz clock, the only clock.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  one-cycle start request; ignored unless IDLE.
- i_stop  input  1  graceful stop request; ignored unless RUN.
- i_mode  input  1  0 = continuous, 1 = burst.
- i_burst_num  input  8  periods per burst (mode 1).
- i_period  input  CNT_W  period length in clocks (default use 500000).
- i_width  input  CNT_W  pulse high time in clocks (default use 875).
- i_delay  input  CNT_W  channel-0 offset from period start (default use 250000).
- i_stagger  input  CNT_W  extra offset per channel index.
- i_ch_mask  input  CH_NUM  1 = channel enabled.
- o_bk_pulse  output  CH_NUM  feedback pulses, registered.
- o_busy  output  1  high in RUN.
- o_done  output  1  one-cycle pulse on run completion.
- o_err  output  1  one-cycle pulse on rejected start.
- o_period_cnt  output  CNT_P  completed periods of current/last run, saturating.

Behaviour:
- Reset (sync, active-high, i_rst sampled at i_clk_25m edge): state IDLE; all outputs 0; o_period_cnt 0; internal counters 0. Reset mid-run aborts immediately; pulses drop the next cycle.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on i_start when the config is valid:
  - Latch all i_* config fields and i_ch_mask. Later input changes have no effect until the next start.
  - Clear o_period_cnt.
  - First RUN cycle is cycle 0, with phase cnt = 0.
- Config validation is done on the i_start cycle. Invalid when any of:
  - i_period < 2;
  - i_width == 0;
  - i_mode == 1 and i_burst_num == 0;
  - delay + (CH_NUM-1)*stagger + width > period-1, evaluated at CNT_W+8 bits with no truncation.
  - Invalid config: o_err=1 for one cycle, stay IDLE.
- Channel start offsets: start_k = delay + k*stagger, computed by accumulation at latch time, not by a multiplier.
- RUN:
  - cnt increments each cycle and wraps period-1 -> 0.
  - Each wrap increments o_period_cnt, saturating at all-ones.
- Pulse timing:
  - o_bk_pulse[k] goes 1 at the edge after cnt == start_k and goes 0 at the edge after cnt == start_k+width.
  - Net effect: high for exactly width cycles, during the cycles in which cnt = start_k+1 .. start_k+width.
  - Masked channels stay 0.
  - Validation guarantees every pulse finishes inside its period; no pulse is ever truncated.
- Mode 0 (continuous):
  - Runs until i_stop.
  - i_stop is registered as a pending flag; the current period completes (cnt reaches period-1), then -> DONE.
- Mode 1 (burst):
  - After i_burst_num wraps -> DONE.
  - i_stop also ends the burst early, at the current period end.
- DONE: one cycle; o_done=1, o_busy=0, all pulses 0; then -> IDLE. o_period_cnt holds its value until the next accepted start.
- Simultaneous events:
  - i_start together with i_stop in IDLE: start accepted, stop dropped.
  - i_start in RUN or DONE: ignored; no o_err.
  - i_rst has priority over everything.
- o_busy = 1 exactly in RUN.

Test Plan:
- CH_NUM=4, period=100, width=5, delay=10, stagger=20, mask=4'hF, burst num=2:
  - ch k high in cycles 11+20k..15+20k and 111+20k..115+20k.
  - o_done at cycle 200; o_period_cnt=2; o_busy low from cycle 200.
- Continuous, period=50, width=3, delay=5, stagger=0, i_stop asserted at cycle 120:
  - Pulses high at cnt 6..8 of each period; pulses at cycles 106..108 occur.
  - No pulse after the period ending at cycle 149; o_done at cycle 150; o_period_cnt=3.
- Invalid configs: period=1; width=0; burst num=0; period=100, delay=90, width=10 with CH_NUM=1:
  - Each gives o_err for one cycle, o_busy stays 0, o_bk_pulse stays 0.
- i_ch_mask=4'b0101 with test 1 config: channels 1 and 3 stay 0; channels 0 and 2 unchanged from test 1.
- Reset mid-pulse: assert i_rst at cycle 13 of test 1 → all outputs 0 next cycle, state IDLE. A fresh i_start then restarts at cycle 0 timing.
- Defaults, 1 channel (period=500000, width=875, delay=250000, continuous):
  - ch0 high at cnt 250001..250875 of every period.
  - o_period_cnt increments every 500000 cycles; i_start while busy is ignored.

Source files
------------

// File: rtl/bk_test_pulse_gen_nch.sv
// Multi-channel breakdown-test feedback pulse generator on the 25 MHz domain.
// Run-time period/width/delay/stagger, continuous or counted-burst operation.
`timescale 1ns/1ps

module bk_test_pulse_gen_nch #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 20,
    parameter int CNT_P  = 16
) (
    input  logic              i_clk_25m,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_mode,
    input  logic [7:0]        i_burst_num,
    input  logic [CNT_W-1:0]  i_period,
    input  logic [CNT_W-1:0]  i_width,
    input  logic [CNT_W-1:0]  i_delay,
    input  logic [CNT_W-1:0]  i_stagger,
    input  logic [CH_NUM-1:0] i_ch_mask,
    output logic [CH_NUM-1:0] o_bk_pulse,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_P-1:0]  o_period_cnt
);

    localparam int               WIDE_W     = CNT_W + 8;
    localparam logic [CNT_W-1:0] PERIOD_MIN = {{(CNT_W-2){1'b0}}, 2'b10};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_P-1:0] PCNT_ONE   = {{(CNT_P-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   pmax_r;
    logic               mode_r;
    logic [7:0]         burst_last_r;
    logic [CH_NUM-1:0]  mask_r;
    logic               stop_pend_r;
    logic [CNT_W-1:0]   start_r [CH_NUM];
    logic [CNT_W-1:0]   end_r   [CH_NUM];
    logic [CH_NUM-1:0]  pulse_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [CNT_P-1:0]   period_cnt_r;

    logic [WIDE_W-1:0]  acc_s;
    logic [WIDE_W-1:0]  last_s;
    logic [CNT_W-1:0]   start_s [CH_NUM];
    logic [CNT_W-1:0]   end_s   [CH_NUM];
    logic               cfg_bad_s;

    // Channel offsets by accumulation and start-time config validation at full width
    always_comb begin
        acc_s  = {8'b0, i_delay};
        last_s = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            start_s[k] = acc_s[CNT_W-1:0];
            end_s[k]   = acc_s[CNT_W-1:0] + i_width;
            last_s     = acc_s;
            acc_s      = acc_s + {8'b0, i_stagger};
        end
        // The last channel has the latest end; it must fall within cnt = period-1.
        cfg_bad_s = (i_period < PERIOD_MIN) ||
                    (i_width == '0) ||
                    (i_mode && (i_burst_num == 8'd0)) ||
                    ((last_s + {8'b0, i_width}) >= {8'b0, i_period});
    end

    // Run FSM: phase counter, channel pulse drivers and all registered outputs
    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            pmax_r       <= '0;
            mode_r       <= 1'b0;
            burst_last_r <= 8'd0;
            mask_r       <= '0;
            stop_pend_r  <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) begin
                start_r[k] <= '0;
                end_r[k]   <= '0;
            end
            pulse_r      <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            period_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= i_start && cfg_bad_s;
                    if (i_start && !cfg_bad_s) begin
                        state_r      <= ST_RUN;
                        busy_r       <= 1'b1;
                        cnt_r        <= '0;
                        pmax_r       <= i_period - CNT_ONE;
                        mode_r       <= i_mode;
                        burst_last_r <= i_burst_num - 8'd1;
                        mask_r       <= i_ch_mask;
                        stop_pend_r  <= 1'b0;
                        period_cnt_r <= '0;
                        for (int k = 0; k < CH_NUM; k++) begin
                            start_r[k] <= start_s[k];
                            end_r[k]   <= end_s[k];
                        end
                    end
                end
                ST_RUN: begin
                    stop_pend_r <= stop_pend_r || i_stop;
                    for (int k = 0; k < CH_NUM; k++) begin
                        if (mask_r[k] && (cnt_r == start_r[k])) begin
                            pulse_r[k] <= 1'b1;
                        end else if (cnt_r == end_r[k]) begin
                            pulse_r[k] <= 1'b0;
                        end
                    end
                    if (cnt_r == pmax_r) begin
                        cnt_r <= '0;
                        if (period_cnt_r != '1) begin
                            period_cnt_r <= period_cnt_r + PCNT_ONE;
                        end
                        // A stop seen during this period, or the last burst period, ends the run here.
                        if (stop_pend_r || i_stop ||
                            (mode_r && (period_cnt_r == CNT_P'(burst_last_r)))) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pulse_r <= '0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b0;
                    stop_pend_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    pulse_r <= '0;
                end
            endcase
        end
    end

    assign o_bk_pulse   = pulse_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_err        = err_r;
    assign o_period_cnt = period_cnt_r;

endmodule
